// File: rtl/request_encoder_32to5_pkg.sv
// Shared constants and FSM encoding for the request encoder.
package request_encoder_32to5_pkg;

  localparam int N_LINES = 32;
  localparam int CODE_W  = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder_32to5.sv
// Combinational lowest-index-first priority encoder.
module priority_encoder_32to5 #(
  parameter int N_LINES = request_encoder_32to5_pkg::N_LINES,
  parameter int CODE_W  = request_encoder_32to5_pkg::CODE_W
) (
  input  logic [N_LINES-1:0] i_vec,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_found
);

  // Scan downward so the lowest set index is the last to win.
  always_comb begin
    o_code  = '0;
    o_found = 1'b0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_code  = CODE_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_encoder_32to5.sv
// Captures request pulses into a pending set and
// presents them one code per handshake, lowest first.
module request_encoder_32to5 #(
  parameter int N_LINES = request_encoder_32to5_pkg::N_LINES,
  parameter int CODE_W  = request_encoder_32to5_pkg::CODE_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N_LINES-1:0] Req,
  input  logic               Enable,
  input  logic               Ready,
  output logic [CODE_W-1:0]  Code,
  output logic               Valid,
  output logic [N_LINES-1:0] Pending,
  output logic               Any,
  output logic               Overrun
);

  import request_encoder_32to5_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CODE_W-1:0]    r_code;
  logic [CODE_W-1:0]    w_code_nxt;
  logic [N_LINES-1:0]   r_pending;
  logic                 r_overrun;

  logic [N_LINES-1:0]   w_clr;
  logic [N_LINES-1:0]   w_set;
  logic [N_LINES-1:0]   w_avail;
  logic [CODE_W-1:0]    w_idx;
  logic                 w_found;
  logic                 w_ovr_hit;

  assign w_clr = (r_state == PRESENT && Ready)
               ? (N_LINES'(1) << r_code)
               : '0;
  assign w_set = Req & {N_LINES{Enable}};

  // Selection sees only registered lines; same-cycle Req waits.
  assign w_avail   = r_pending & ~w_clr;
  assign w_ovr_hit = |(w_set & w_avail);

  priority_encoder_32to5 #(
    .N_LINES (N_LINES),
    .CODE_W  (CODE_W)
  ) u_penc (
    .i_vec   (w_avail),
    .o_code  (w_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = PRESENT;
          w_code_nxt  = w_idx;
        end
      end
      PRESENT: begin
        if (Ready) begin
          if (w_found) begin
            w_code_nxt = w_idx;
          end else begin
            w_state_nxt = IDLE;
            w_code_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_code_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pending <= w_avail | w_set;
      r_overrun <= r_overrun | w_ovr_hit;
    end
  end

  assign Code    = r_code;
  assign Valid   = (r_state == PRESENT);
  assign Pending = r_pending;
  assign Any     = |r_pending;
  assign Overrun = r_overrun;

endmodule

// File: tb/tb_request_encoder_32to5.sv
// Self-checking bench: directed scenarios plus random
// traffic against a behavioural pending-set model.
module tb_request_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req = '0;
  logic        en  = 1'b1;
  logic        rdy = 1'b0;
  logic [4:0]  code;
  logic        valid;
  logic [31:0] pend;
  logic        any;
  logic        ovr;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_pend [32];
  bit m_valid;
  int m_code;
  bit m_ovr;

  always #5 clk = ~clk;

  request_encoder_32to5 dut (
    .Clk     (clk),
    .Reset   (rst),
    .Req     (req),
    .Enable  (en),
    .Ready   (rdy),
    .Code    (code),
    .Valid   (valid),
    .Pending (pend),
    .Any     (any),
    .Overrun (ovr)
  );

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input logic [31:0] r, input bit e,
                            input bit y, input bit rs);
    bit old [32];
    bit served;
    int scode;
    int nxt;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0;
      m_code  = 0;
      m_ovr   = 0;
      return;
    end
    old    = m_pend;
    served = m_valid && y;
    scode  = m_code;
    if (served) m_pend[scode] = 0;
    if (!m_valid || y) begin
      nxt = -1;
      for (int i = 0; i < 32 && nxt < 0; i++) if (m_pend[i]) nxt = i;
      m_valid = (nxt >= 0);
      m_code  = m_valid ? nxt : 0;
    end
    for (int i = 0; i < 32; i++) begin
      if (e && r[i]) begin
        if (old[i] && !(served && scode == i)) m_ovr = 1;
        m_pend[i] = 1;
      end
    end
  endtask

  // Inputs are applied at negedge; returns at the next negedge.
  task automatic cycle(input logic [31:0] r, input bit e,
                       input bit y, input bit rs);
    req = r;
    en  = e;
    rdy = y;
    rst = rs;
    @(posedge clk);
    model_step(r, e, y, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle('1, 1, 1, 1);
    total++;
    if ({valid, code, pend, any, ovr} !== '0) begin
      bad++;
      $display("FAIL reset: v=%0b c=%0d p=%h a=%0b o=%0b required all 0",
               valid, code, pend, any, ovr);
    end
  endtask

  task automatic test_single();
    cycle(32'h10, 1, 1, 0);
    total++;
    if (valid !== 1'b0 || pend !== 32'h10 || any !== 1'b1) begin
      bad++;
      $display("FAIL single_capture: v=%0b p=%h a=%0b required v=0 p=10 a=1",
               valid, pend, any);
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b1 || code !== 5'd4) begin
      bad++;
      $display("FAIL single_present: v=%0b c=%0d required v=1 c=4",
               valid, code);
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b0 || pend !== '0 || any !== 1'b0 || code !== 5'd0) begin
      bad++;
      $display("FAIL single_done: v=%0b c=%0d p=%h a=%0b required 0",
               valid, code, pend, any);
    end
  endtask

  task automatic test_multi();
    int exp_c [3] = '{0, 2, 31};
    cycle(32'h8000_0005, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1, 1, 0);
      total++;
      if (valid !== 1'b1 || code !== 5'(exp_c[k])) begin
        bad++;
        $display("FAIL multi_order%0d: v=%0b c=%0d required v=1 c=%0d",
                 k, valid, code, exp_c[k]);
      end
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b0 || pend !== '0) begin
      bad++;
      $display("FAIL multi_idle: v=%0b p=%h required v=0 p=0", valid, pend);
    end
  endtask

  task automatic test_backpressure();
    cycle(32'h300, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle('0, 1, 0, 0);
      total++;
      if (valid !== 1'b1 || code !== 5'd8 || pend !== 32'h300) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%0b c=%0d p=%h required v=1 c=8 p=300",
                 k, valid, code, pend);
      end
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b1 || code !== 5'd9) begin
      bad++;
      $display("FAIL bp_next: v=%0b c=%0d required v=1 c=9", valid, code);
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b0 || pend !== '0) begin
      bad++;
      $display("FAIL bp_idle: v=%0b p=%h required v=0 p=0", valid, pend);
    end
  endtask

  task automatic test_set_clear();
    cycle(32'h8, 1, 1, 0);
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b1 || code !== 5'd3) begin
      bad++;
      $display("FAIL sc_first: v=%0b c=%0d required v=1 c=3", valid, code);
    end
    cycle(32'h8, 1, 1, 0);
    total++;
    if (pend !== 32'h8 || ovr !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL sc_setwins: p=%h o=%0b v=%0b required p=8 o=0 v=0",
               pend, ovr, valid);
    end
    cycle('0, 1, 1, 0);
    total++;
    if (valid !== 1'b1 || code !== 5'd3 || ovr !== 1'b0) begin
      bad++;
      $display("FAIL sc_again: v=%0b c=%0d o=%0b required v=1 c=3 o=0",
               valid, code, ovr);
    end
    cycle('0, 1, 1, 0);
  endtask

  task automatic test_overrun_enable();
    cycle(32'h1, 1, 0, 0);
    total++;
    if (ovr !== 1'b0 || pend !== 32'h1) begin
      bad++;
      $display("FAIL ovr_first: o=%0b p=%h required o=0 p=1", ovr, pend);
    end
    cycle(32'h1, 1, 0, 0);
    total++;
    if (ovr !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: o=%0b required 1", ovr);
    end
    cycle('1, 0, 0, 0);
    total++;
    if (pend !== 32'h1 || valid !== 1'b1 || code !== 5'd0 || ovr !== 1'b1) begin
      bad++;
      $display("FAIL en_block: p=%h v=%0b c=%0d o=%0b required p=1 v=1 c=0 o=1",
               pend, valid, code, ovr);
    end
    cycle('1, 0, 1, 0);
    total++;
    if (pend !== '0 || valid !== 1'b0 || ovr !== 1'b1) begin
      bad++;
      $display("FAIL en_drain: p=%h v=%0b o=%0b required p=0 v=0 o=1",
               pend, valid, ovr);
    end
    cycle('0, 1, 0, 1);
    total++;
    if (ovr !== 1'b0) begin
      bad++;
      $display("FAIL ovr_reset: o=%0b required 0", ovr);
    end
  endtask

  task automatic test_reset_mid();
    cycle(32'h0F0F_0000, 1, 0, 0);
    cycle('0, 1, 0, 0);
    total++;
    if (valid !== 1'b1 || code !== 5'd16) begin
      bad++;
      $display("FAIL rm_pre: v=%0b c=%0d required v=1 c=16", valid, code);
    end
    cycle(32'h1, 1, 1, 1);
    total++;
    if ({valid, code, pend, any, ovr} !== '0) begin
      bad++;
      $display("FAIL rm_reset: v=%0b c=%0d p=%h a=%0b o=%0b required all 0",
               valid, code, pend, any, ovr);
    end
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1, 1, 0);
      total++;
      if (valid !== 1'b0 || pend !== '0) begin
        bad++;
        $display("FAIL rm_after%0d: v=%0b p=%h required v=0 p=0",
                 k, valid, pend);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit e, y, rs;
    for (int k = 0; k < 400; k++) begin
      r  = $urandom & $urandom & $urandom;
      e  = ($urandom_range(0, 3) != 0);
      y  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 63) == 0);
      cycle(r, e, y, rs);
      total++;
      if (valid !== m_valid || code !== 5'(m_code) ||
          pend !== m_pend_vec() || any !== (m_pend_vec() != 0) ||
          ovr !== m_ovr) begin
        bad++;
        $display("FAIL rand%0d: v=%0b c=%0d p=%h a=%0b o=%0b required v=%0b c=%0d p=%h o=%0b",
                 k, valid, code, pend, any, ovr,
                 m_valid, m_code, m_pend_vec(), m_ovr);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_set_clear();
    test_overrun_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
